fu_sequencer: RTL
=================

Name: fu_sequencer

Overview:
- Command-driven issuer for the 16-bit function unit (ALU + shifter). It accepts register-level commands over a valid/ready handshake and holds an internal register file.
- It drives the function unit's A/B/S/MF inputs and samples its result and flags after a fixed latency. It writes the result back, then returns a response over a second valid/ready handshake.
- It is the initiator end of the function-unit interface and sits between the control path and the function unit.

Parameters:
- WIDTH, 16, datapath width; must match the function unit.
- NREGS, 8, register file depth.
- REG_AW, 3, register address width; equals log2(NREGS).
- FU_LAT, 2, cycles fu_* inputs are held before fu_data/flags are sampled; must be >= 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 EXEC, 01 LOADI, 10 READ, 11 reserved.
- cmd_s  in  4  function select forwarded to the function unit.
- cmd_mf  in  1  0 = ALU result, 1 = shifter result.
- cmd_rd  in  REG_AW  destination register.
- cmd_ra  in  REG_AW  source A; also the READ address.
- cmd_rb  in  REG_AW  source B.
- cmd_imm  in  WIDTH  LOADI immediate.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  result, immediate, or read value.
- rsp_flags  out  6  {V,C,Z,N,IL,IR} flag register after the command.
- rsp_err  out  1  reserved opcode.
- fu_a, fu_b  out  WIDTH  function unit operands.
- fu_s  out  4  function unit select.
- fu_mf  out  1  function unit mux select.
- fu_data  in  WIDTH  function unit result.
- fu_v, fu_c, fu_zr, fu_n, fu_il, fu_ir  in  1 each  function unit flags.

Behaviour:
- Reset (reset_n low, takes effect immediately regardless of clock):
  - State returns to IDLE.
  - All registers, the flag register, fu_a, fu_b, fu_s, fu_mf, rsp_valid, rsp_data, rsp_flags and rsp_err go to 0.
  - Any in-flight command is dropped and no response is produced.
  - No command is accepted while reset_n is low.
- States: IDLE, ISSUE, RESP.
- cmd_ready = 1 only in IDLE. A command is accepted on an edge where cmd_valid and cmd_ready are both 1.
- IDLE, on accept:
  - EXEC: latch fu_a = reg[ra], fu_b = reg[rb], fu_s = cmd_s, fu_mf = cmd_mf, and latch rd. Load the counter with FU_LAT-1. Go to ISSUE.
  - LOADI: reg[rd] = cmd_imm and rsp_data = cmd_imm, both on the accept edge. Go to RESP.
  - READ: rsp_data = reg[ra]. Go to RESP.
  - Reserved (11): rsp_err = 1 and rsp_data = 0. No register or flag change. Go to RESP.
  - rsp_err = 0 for all other opcodes.
- ISSUE:
  - fu_* stay constant for exactly FU_LAT cycles.
  - On the edge where the counter is 0: sample fu_data, write reg[rd], set rsp_data = fu_data, then go to RESP.
  - Flag update on that same edge: if mf = 0, update V,C,Z,N from fu_v, fu_c, fu_zr, fu_n and keep IL,IR. If mf = 1, update IL,IR and keep V,C,Z,N.
- Operand capture: operands are captured at accept, so rd == ra or rd == rb is safe.
- Hold rules: fu_* keep their last values after ISSUE and change only at the next EXEC accept.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_flags and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid drops and the state goes to IDLE.
  - A new command cannot be accepted on the same edge as the response handshake.
- rsp_flags always mirrors the flag register.
- Latency, where k is the accept edge:
  - EXEC: rsp_valid rises after edge k+FU_LAT.
  - LOADI, READ, reserved: rsp_valid rises after edge k.
  - Minimum EXEC period is FU_LAT+2 cycles.
- No arithmetic is performed locally. Widths are passed through without truncation.

Test Plan:
- Reset: assert reset_n low mid-ISSUE, with rsp_ready held high so a missed drop would show a response -> rsp_valid, fu_a and all registers 0 immediately; no response after release; cmd_ready = 1 in IDLE.
- LOADI r1=0x1234, then READ r1 -> LOADI rsp_data = 0x1234 one cycle after accept with rsp_err = 0; READ returns 0x1234.
- LOADI r2=0x0001; EXEC mf=0 s=4'h1 ra=1 rb=2 rd=3, bench model returns 0x1235 with fu_c=1 after 2 cycles -> fu_a=0x1234 and fu_b=0x0001 stable for 2 cycles; r3=0x1235; rsp_flags C=1.
- EXEC mf=1 with fu_il=1, fu_v=1 -> IL=1; V,C,Z,N unchanged from the previous command.
- Hold rsp_ready low for 5 cycles while cmd_valid=1 -> rsp_valid and rsp_data stable; cmd_ready=0; no second command accepted.
- cmd_op=11 -> rsp_err=1, rsp_data=0; registers and flags unchanged; the next command has rsp_err=0.

Source files
------------

// File: rtl/fu_sequencer.sv
// Command-driven issuer for the 16-bit function unit: owns a small register file,
// drives the FU operands for a fixed latency, writes back and answers over valid/ready.
module fu_sequencer #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3,
  parameter int FU_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_s,
  input  logic              cmd_mf,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [5:0]        rsp_flags,
  output logic              rsp_err,
  output logic [WIDTH-1:0]  fu_a,
  output logic [WIDTH-1:0]  fu_b,
  output logic [3:0]        fu_s,
  output logic              fu_mf,
  input  logic [WIDTH-1:0]  fu_data,
  input  logic              fu_v,
  input  logic              fu_c,
  input  logic              fu_zr,
  input  logic              fu_n,
  input  logic              fu_il,
  input  logic              fu_ir
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] OP_EXEC  = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam int         CW       = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  rf [NREGS];
  logic [5:0]        flags_q;          // {V,C,Z,N,IL,IR}
  logic [REG_AW-1:0] rd_q;
  logic [CW-1:0]     cnt_q;
  logic              accept;
  logic              sample;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign sample    = (state_q == ISSUE) && (cnt_q == '0);
  assign rsp_flags = flags_q;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (cmd_op == OP_EXEC) ? ISSUE : RESP;
      ISSUE:   if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the register file is reset explicitly because reads after reset must
  // return zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      flags_q  <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      fu_a     <= '0;
      fu_b     <= '0;
      fu_s     <= '0;
      fu_mf    <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_err <= (cmd_op == 2'b11);
      unique case (cmd_op)
        OP_EXEC: begin
          // Operands are captured here, so rd may alias ra or rb.
          fu_a  <= rf[cmd_ra];
          fu_b  <= rf[cmd_rb];
          fu_s  <= cmd_s;
          fu_mf <= cmd_mf;
          rd_q  <= cmd_rd;
          cnt_q <= CW'(FU_LAT - 1);
        end
        OP_LOADI: begin
          rf[cmd_rd] <= cmd_imm;
          rsp_data   <= cmd_imm;
        end
        OP_READ:  rsp_data <= rf[cmd_ra];
        default:  rsp_data <= '0;
      endcase
    end else if (state_q == ISSUE) begin
      if (sample) begin
        rf[rd_q] <= fu_data;
        rsp_data <= fu_data;
        // ALU results own V,C,Z,N; shifter results own IL,IR.
        if (!fu_mf) flags_q[5:2] <= {fu_v, fu_c, fu_zr, fu_n};
        else        flags_q[1:0] <= {fu_il, fu_ir};
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule
